mem_stage_sram_ctrl: RTL and testbench

- MEM stage of the 5-stage pipeline, directly downstream of the EXE/MEM pipeline register.
- Consumes the registered ALU result (address), store data, and control bits.
- Performs 32-bit loads and stores on an external 16-bit asynchronous SRAM as two half-word accesses.
- Asserts freeze to stall the upstream pipeline while an access is in flight; presents load data and passes through wb_en/dest toward the MEM/WB register.

---
 rtl/mem_stage_sram_ctrl_pkg.sv | 16 +
 rtl/mem_stage_sram_ctrl_if.sv | 14 +
 rtl/mem_stage_sram_ctrl_wait_counter.sv | 30 +++
 rtl/mem_stage_sram_ctrl.sv | 118 +++++++++++
 tb/tb_mem_stage_sram_ctrl.sv | 186 ++++++++++++++++++
 5 files changed

// File: rtl/mem_stage_sram_ctrl_pkg.sv
// Shared types and defaults for the MEM-stage SRAM controller.
// Holds the FSM state encoding and the SRAM geometry/timing defaults.
package mem_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LO   = 2'd1,
      HI   = 2'd2,
      DONE = 2'd3
   } state_t;

   localparam int SRAM_AW_DFLT   = 18;
   localparam int SRAM_WAIT_DFLT = 2;
   localparam int CNT_W          = 4;  // wide enough for waits up to 15

endpackage

// File: rtl/mem_stage_sram_ctrl_if.sv
// 16-bit asynchronous SRAM bus between the MEM-stage controller and the memory.
// master = controller side, slave = SRAM (or its model).
interface mem_stage_sram_ctrl_if #(
   parameter int AW = mem_pkg::SRAM_AW_DFLT
);
   logic [AW-1:0] addr;
   logic [15:0]   wdata;
   logic [15:0]   rdata;
   logic          we_n;
   logic          oe_n;

   modport master (output addr, output wdata, output we_n, output oe_n, input rdata);
   modport slave  (input addr, input wdata, input we_n, input oe_n, output rdata);
endinterface

// File: rtl/mem_stage_sram_ctrl_wait_counter.sv
// Loadable wait counter with a terminal-count flag; tc is high on the last
// enabled cycle of a WAIT-cycle window, after which the count wraps to 0.
module sram_wait_counter
   import mem_pkg::*;
#(
   parameter int WAIT = SRAM_WAIT_DFLT
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   input  logic             en,
   output logic [CNT_W-1:0] count,
   output logic             tc
);

   assign tc = en && (count == CNT_W'(WAIT - 1));

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (en) begin
         count <= tc ? '0 : count + 1'b1;
      end
   end

endmodule

// File: rtl/mem_stage_sram_ctrl.sv
// MEM stage: 32-bit loads/stores on a 16-bit async SRAM as two half-word accesses,
// freezing the upstream pipeline while the access is in flight.
module mem_stage_sram_ctrl
   import mem_pkg::*;
#(
   parameter int SRAM_WAIT = SRAM_WAIT_DFLT,
   parameter int SRAM_AW   = SRAM_AW_DFLT
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        mem_read,
   input  logic        mem_write,
   input  logic        wb_en,
   input  logic [4:0]  dest,
   input  logic [31:0] ALU_result,
   input  logic [31:0] reg2,
   mem_stage_sram_ctrl_if.master sram,
   output logic        freeze,
   output logic [31:0] mem_result,
   output logic        wb_en_out,
   output logic [4:0]  dest_out
);

   state_t state, next_state;

   logic               req, store_op, load_op, busy;
   logic [SRAM_AW-2:0] word;
   logic [CNT_W-1:0]   count;
   logic               tc;

   logic [SRAM_AW-1:0] addr_q, addr_d;
   logic [15:0]        wdata_q, wdata_d;
   logic               we_n_q, we_n_d, oe_n_q, oe_n_d;

   logic unused_addr_bits;
   assign unused_addr_bits = ^{ALU_result[31:SRAM_AW+1], ALU_result[1:0]};

   assign req      = mem_read | mem_write;
   assign store_op = mem_write;
   assign load_op  = mem_read & ~mem_write;
   assign busy     = (state == LO) || (state == HI);
   assign word     = ALU_result[SRAM_AW:2];

   assign wb_en_out = wb_en;
   assign dest_out  = dest;

   sram_wait_counter #(.WAIT(SRAM_WAIT)) u_wait (
      .clk      (clk),
      .rst      (rst),
      .load     (state == IDLE),
      .load_val ('0),
      .en       (busy),
      .count    (count),
      .tc       (tc)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= next_state;
   end

   // NOTE: every comb output gets a default first, so no path can infer a latch.
   always_comb begin
      next_state = state;
      unique case (state)
         IDLE:    if (req) next_state = LO;
         LO:      if (tc)  next_state = HI;
         HI:      if (tc)  next_state = DONE;
         DONE:             next_state = IDLE;
         default:          next_state = IDLE;
      endcase
   end

   // SRAM drive is decoded from next_state and registered, so strobes change
   // only at clock edges together with the address.
   always_comb begin
      freeze  = rst & (((state == IDLE) & req) | busy);
      addr_d  = addr_q;
      wdata_d = wdata_q;
      we_n_d  = 1'b1;
      oe_n_d  = 1'b1;
      if (next_state == LO || next_state == HI) begin
         addr_d  = {word, (next_state == HI)};
         wdata_d = (next_state == HI) ? reg2[31:16] : reg2[15:0];
         we_n_d  = ~store_op;
         oe_n_d  = ~load_op;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         addr_q  <= '0;
         wdata_q <= '0;
         we_n_q  <= 1'b1;
         oe_n_q  <= 1'b1;
      end else begin
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         we_n_q  <= we_n_d;
         oe_n_q  <= oe_n_d;
      end
   end

   assign sram.addr  = addr_q;
   assign sram.wdata = wdata_q;
   assign sram.we_n  = we_n_q;
   assign sram.oe_n  = oe_n_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mem_result <= '0;
      end else if (tc && load_op) begin
         if (state == LO) mem_result[15:0]  <= sram.rdata;
         if (state == HI) mem_result[31:16] <= sram.rdata;
      end
   end

endmodule

// File: tb/tb_mem_stage_sram_ctrl.sv
// Directed bench for mem_stage_sram_ctrl: two instances (SRAM_WAIT=2 and 1),
// each with a small behavioural SRAM model.
module tb_mem_stage_sram_ctrl;
   import mem_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   logic        a_rd = 0, a_wr = 0, b_rd = 0, b_wr = 0;
   logic        wb_en = 0;
   logic [4:0]  dest = 0;
   logic [31:0] a_alu = 0, a_r2 = 0, b_alu = 0, b_r2 = 0;
   logic        a_fz, b_fz, a_wb, b_wb;
   logic [4:0]  a_dest, b_dest;
   logic [31:0] a_res, b_res;

   mem_stage_sram_ctrl_if #(.AW(18)) sif_a ();
   mem_stage_sram_ctrl_if #(.AW(18)) sif_b ();

   mem_stage_sram_ctrl #(.SRAM_WAIT(2), .SRAM_AW(18)) dut (
      .clk(clk), .rst(rst), .mem_read(a_rd), .mem_write(a_wr), .wb_en(wb_en),
      .dest(dest), .ALU_result(a_alu), .reg2(a_r2), .sram(sif_a),
      .freeze(a_fz), .mem_result(a_res), .wb_en_out(a_wb), .dest_out(a_dest));

   mem_stage_sram_ctrl #(.SRAM_WAIT(1), .SRAM_AW(18)) dut1 (
      .clk(clk), .rst(rst), .mem_read(b_rd), .mem_write(b_wr), .wb_en(1'b0),
      .dest(5'd0), .ALU_result(b_alu), .reg2(b_r2), .sram(sif_b),
      .freeze(b_fz), .mem_result(b_res), .wb_en_out(b_wb), .dest_out(b_dest));

   // SRAM models: preloaded while in reset, written on clock edges with we_n low.
   logic [15:0] mem_a [256];
   logic [15:0] mem_b [256];
   assign sif_a.rdata = !sif_a.oe_n ? mem_a[sif_a.addr[7:0]] : 16'h0;
   assign sif_b.rdata = !sif_b.oe_n ? mem_b[sif_b.addr[7:0]] : 16'h0;

   always @(posedge clk) begin
      if (!rst) begin
         mem_a[8'h10] <= 16'h1234;
         mem_a[8'h11] <= 16'h5678;
      end else if (!sif_a.we_n) begin
         mem_a[sif_a.addr[7:0]] <= sif_a.wdata;
      end
   end

   always @(posedge clk) begin
      if (!rst) begin
         mem_b[8'h06] <= 16'h3333;
         mem_b[8'h07] <= 16'h4444;
      end else if (!sif_b.we_n) begin
         mem_b[sif_b.addr[7:0]] <= sif_b.wdata;
      end
   end

   int total = 0;
   int bad   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%h expected=%h", tag, got, exp);
      end
   endtask

   logic        fz_s  [16];
   logic        we_s  [16];
   logic        oe_s  [16];
   logic [17:0] ad_s  [16];
   logic [15:0] wd_s  [16];
   logic [31:0] res_s [16];
   int fz_n, we_cnt, oe_cnt, ovl;

   // Present one instruction for n cycles; sample each cycle 1 time unit after the falling edge.
   task automatic run(input bit which, input logic rd, input logic wr,
                      input logic [31:0] alu, input logic [31:0] r2, input int n);
      fz_n = 0; we_cnt = 0; oe_cnt = 0; ovl = 0;
      for (int c = 0; c < n; c++) begin
         @(negedge clk);
         if (c == 0) begin
            if (!which) begin a_rd = rd; a_wr = wr; a_alu = alu; a_r2 = r2; end
            else        begin b_rd = rd; b_wr = wr; b_alu = alu; b_r2 = r2; end
         end
         #1;
         fz_s[c]  = which ? b_fz         : a_fz;
         we_s[c]  = which ? sif_b.we_n   : sif_a.we_n;
         oe_s[c]  = which ? sif_b.oe_n   : sif_a.oe_n;
         ad_s[c]  = which ? sif_b.addr   : sif_a.addr;
         wd_s[c]  = which ? sif_b.wdata  : sif_a.wdata;
         res_s[c] = which ? b_res        : a_res;
         if (fz_s[c])             fz_n++;
         if (!we_s[c])            we_cnt++;
         if (!oe_s[c])            oe_cnt++;
         if (!we_s[c] && !oe_s[c]) ovl++;
      end
   endtask

   int fz_first, ovl_first;

   initial begin
      repeat (2) @(negedge clk);
      #1;
      check("rst_we_n",  32'(sif_a.we_n),  32'd1);
      check("rst_oe_n",  32'(sif_a.oe_n),  32'd1);
      check("rst_addr",  32'(sif_a.addr),  32'd0);
      check("rst_wdata", 32'(sif_a.wdata), 32'd0);
      check("rst_freeze", 32'(a_fz),       32'd0);
      check("rst_result", a_res,           32'd0);
      @(negedge clk);
      rst = 1'b1;

      // Reset asserted while a store is in its low-half window.
      run(0, 0, 1, 32'h30, 32'h1111_2222, 2);
      check("midlo_we_active", 32'(we_s[1]), 32'd0);
      #1 rst = 1'b0;
      #1;
      check("midlo_rst_we_n",   32'(sif_a.we_n), 32'd1);
      check("midlo_rst_oe_n",   32'(sif_a.oe_n), 32'd1);
      check("midlo_rst_freeze", 32'(a_fz),       32'd0);
      @(negedge clk);
      rst = 1'b1; a_wr = 1'b0;
      #1;
      check("midlo_state_idle", 32'(dut.state), 32'(IDLE));
      check("midlo_freeze_idle", 32'(a_fz), 32'd0);

      // Store 0xDEADBEEF to byte address 0x10 -> half-words 0x8 / 0x9.
      run(0, 0, 1, 32'h10, 32'hDEAD_BEEF, 6);
      check("st_freeze_cycles", 32'(fz_n),    32'd5);
      check("st_we_cycles",     32'(we_cnt),  32'd4);
      check("st_oe_cycles",     32'(oe_cnt),  32'd0);
      check("st_lo_addr",       32'(ad_s[1]), 32'h8);
      check("st_lo_wdata",      32'(wd_s[2]), 32'hBEEF);
      check("st_hi_addr",       32'(ad_s[3]), 32'h9);
      check("st_hi_wdata",      32'(wd_s[4]), 32'hDEAD);
      check("st_done_freeze",   32'(fz_s[5]), 32'd0);
      check("st_done_we_n",     32'(we_s[5]), 32'd1);
      check("st_sram_lo",       32'(mem_a[8'h08]), 32'hBEEF);
      check("st_sram_hi",       32'(mem_a[8'h09]), 32'hDEAD);

      // Load the same word back.
      run(0, 1, 0, 32'h10, 32'h0, 6);
      check("ld_freeze_cycles", 32'(fz_n),   32'd5);
      check("ld_oe_cycles",     32'(oe_cnt), 32'd4);
      check("ld_we_cycles",     32'(we_cnt), 32'd0);
      check("ld_result_done",   res_s[5],    32'hDEAD_BEEF);

      // Back-to-back load (0x20 -> 0x56781234) then store to 0x24.
      run(0, 1, 0, 32'h20, 32'h0, 6);
      fz_first  = fz_n;
      ovl_first = ovl;
      check("b2b_ld_result", res_s[5], 32'h5678_1234);
      run(0, 0, 1, 32'h24, 32'hCAFE_F00D, 6);
      check("b2b_fz_start",    32'(fz_s[0]),           32'd1);
      check("b2b_fz_total",    32'(fz_first + fz_n),   32'd10);
      check("b2b_no_overlap",  32'(ovl_first + ovl),   32'd0);
      check("b2b_result_held", res_s[5],               32'h5678_1234);
      check("b2b_sram_lo",     32'(mem_a[8'h12]),      32'hF00D);
      check("b2b_sram_hi",     32'(mem_a[8'h13]),      32'hCAFE);

      // Plain ALU op: no stall, pass-through only.
      wb_en = 1'b1; dest = 5'd7;
      run(0, 0, 0, 32'h55, 32'h0, 3);
      check("alu_freeze",    32'(fz_n),   32'd0);
      check("alu_strobes",   32'(we_cnt + oe_cnt), 32'd0);
      check("alu_wb_en_out", 32'(a_wb),   32'd1);
      check("alu_dest_out",  32'(a_dest), 32'd7);
      wb_en = 1'b0; dest = 5'd0;

      // SRAM_WAIT=1 instance: a load, then read+write together acts as a store.
      run(1, 1, 0, 32'hC, 32'h0, 4);
      check("w1_ld_freeze", 32'(fz_n), 32'd3);
      check("w1_ld_result", res_s[3],  32'h4444_3333);
      run(1, 1, 1, 32'h8, 32'hA5A5_5A5A, 4);
      check("w1_dual_freeze", 32'(fz_n),   32'd3);
      check("w1_dual_we",     32'(we_cnt), 32'd2);
      check("w1_dual_oe",     32'(oe_cnt), 32'd0);
      check("w1_dual_result", res_s[3],    32'h4444_3333);
      check("w1_sram_lo",     32'(mem_b[8'h04]), 32'h5A5A);
      check("w1_sram_hi",     32'(mem_b[8'h05]), 32'hA5A5);
      run(1, 0, 0, 32'h0, 32'h0, 2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
